// File: rtl/pipe_hazard_ctrl.sv
// Pipeline scoreboard: tracks in-flight writers from issue to writeback and
// derives load-use stall, forward selects, flush kill and HLT drain.
module pipe_hazard_ctrl #(
  parameter int STAGES     = 3,
  parameter int NREG       = 16,
  parameter int AW         = $clog2(NREG),
  parameter int LOAD_STAGE = 1,
  parameter int SW         = $clog2(STAGES + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [AW-1:0]     id_src0,
  input  logic [AW-1:0]     id_src1,
  input  logic              id_re0,
  input  logic              id_re1,
  input  logic [AW-1:0]     id_dst,
  input  logic              id_we,
  input  logic              id_load,
  input  logic              id_hlt,
  input  logic              flush,
  output logic              stall,
  output logic              issue,
  output logic [SW-1:0]     fwd_sel0,
  output logic [SW-1:0]     fwd_sel1,
  output logic              wb_we,
  output logic [AW-1:0]     wb_addr,
  output logic [STAGES-1:0] stage_valid,
  output logic              halted
);

  logic [STAGES-1:0]         v_q, we_q, ld_q, ht_q;
  logic [STAGES-1:0][AW-1:0] dst_q;
  logic                      halting_q, halted_q;

  logic          hz0, hz1, found0, found1;
  logic [SW-1:0] sel0, sel1;

  // Scan from the youngest stage up; the first hit is the only one considered.
  always_comb begin
    hz0    = 1'b0;
    hz1    = 1'b0;
    found0 = 1'b0;
    found1 = 1'b0;
    sel0   = '0;
    sel1   = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      if (!found0 && id_re0 && (id_src0 != '0) && v_q[k] && we_q[k] && (dst_q[k] == id_src0)) begin
        found0 = 1'b1;
        if (ld_q[k] && (k < LOAD_STAGE)) hz0 = 1'b1;
        else sel0 = SW'(k + 1);
      end
      if (!found1 && id_re1 && (id_src1 != '0) && v_q[k] && we_q[k] && (dst_q[k] == id_src1)) begin
        found1 = 1'b1;
        if (ld_q[k] && (k < LOAD_STAGE)) hz1 = 1'b1;
        else sel1 = SW'(k + 1);
      end
    end
  end

  assign stall       = id_valid & (hz0 | hz1 | halting_q) & ~flush;
  assign issue       = id_valid & ~stall & ~flush & ~halting_q;
  assign fwd_sel0    = sel0;
  assign fwd_sel1    = sel1;
  assign wb_we       = v_q[STAGES-1] & we_q[STAGES-1];
  assign wb_addr     = dst_q[STAGES-1];
  assign stage_valid = v_q;
  assign halted      = halted_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q       <= '0;
      we_q      <= '0;
      ld_q      <= '0;
      ht_q      <= '0;
      dst_q     <= '0;
      halting_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      for (int unsigned k = 1; k < STAGES; k++) begin
        v_q[k]   <= v_q[k-1];
        we_q[k]  <= we_q[k-1];
        ld_q[k]  <= ld_q[k-1];
        ht_q[k]  <= ht_q[k-1];
        dst_q[k] <= dst_q[k-1];
      end
      // A flushed stage-0 entry is dropped instead of advancing into stage 1.
      if (flush) begin
        v_q[1]   <= 1'b0;
        we_q[1]  <= 1'b0;
        ld_q[1]  <= 1'b0;
        ht_q[1]  <= 1'b0;
        dst_q[1] <= '0;
      end
      if (issue) begin
        v_q[0]   <= 1'b1;
        we_q[0]  <= id_we;
        ld_q[0]  <= id_load;
        ht_q[0]  <= id_hlt;
        dst_q[0] <= id_dst;
      end else begin
        v_q[0]   <= 1'b0;
        we_q[0]  <= 1'b0;
        ld_q[0]  <= 1'b0;
        ht_q[0]  <= 1'b0;
        dst_q[0] <= '0;
      end

      if (issue && id_hlt) begin
        halting_q <= 1'b1;
      end else if (v_q[STAGES-1] && ht_q[STAGES-1]) begin
        halting_q <= 1'b0;
        halted_q  <= 1'b1;
      end else if (flush && v_q[0] && ht_q[0]) begin
        halting_q <= 1'b0;
      end
    end
  end

endmodule
